// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in/serial-out transmitter with a valid/ready load
// handshake, a shift-enable stall input and a complementary serial output pair.
module piso_serial_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_n,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_n_q;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic             accept;

  // Bit that goes on the line first for a given register image.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Register image after one bit has been consumed.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
    else           return {1'b0, w[WIDTH-1:1]};
  endfunction

  assign load_ready = (state_q == IDLE) || (state_q == DONE);
  assign accept     = load_valid & load_ready;
  assign busy       = (state_q == SHIFT);
  assign sout       = sout_q;
  assign sout_n     = sout_n_q;
  assign sout_valid = vld_q;
  assign done       = done_q;

  // Next-state and datapath update; shift_en low in SHIFT holds everything.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = din;
          cnt_d   = '0;
          sout_d  = first_bit(din);
          vld_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_q == LAST_CNT) begin
            // Last bit has been held for its cycle; sout keeps its value.
            state_d = DONE;
            vld_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            shreg_d = advance(shreg_q);
            sout_d  = first_bit(advance(shreg_q));
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; sout_n is registered from the inverse of sout_d
  // so the pair stays complementary in every cycle, including reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sout_q   <= 1'b0;
      sout_n_q <= 1'b1;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sout_q   <= sout_d;
      sout_n_q <= ~sout_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Testbench for piso_serial_tx: an MSB-first and an LSB-first instance share
// the same inputs; accepted words are queued per instance and a monitor checks
// every serial bit, the done pulse timing and the output invariants.
module tb_piso_serial_tx;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         load_valid;
  logic         shift_en;

  logic load_ready_a [2];
  logic sout_a       [2];
  logic sout_n_a     [2];
  logic sout_valid_a [2];
  logic busy_a       [2];
  logic done_a       [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] wq0 [$];
  logic [W-1:0] wq1 [$];

  piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(load_ready_a[0]), .shift_en(shift_en), .sout(sout_a[0]),
    .sout_n(sout_n_a[0]), .sout_valid(sout_valid_a[0]), .busy(busy_a[0]),
    .done(done_a[0])
  );

  piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(load_ready_a[1]), .shift_en(shift_en), .sout(sout_a[1]),
    .sout_n(sout_n_a[1]), .sout_valid(sout_valid_a[1]), .busy(busy_a[1]),
    .done(done_a[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input bit ok, input string name, input int k,
                     input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  // Reference: i-th transmitted bit of word w (k=0 MSB-first, k=1 LSB-first).
  function automatic logic ref_bit(input logic [W-1:0] w, input int i, input int k);
    return (k == 0) ? w[W-1-i] : w[i];
  endfunction

  // One stimulus cycle; words that will be accepted at the next edge are queued.
  task automatic cyc(input logic lv, input logic [W-1:0] d, input logic se,
                     output bit acc);
    @(posedge clk);
    #1;
    load_valid = lv;
    din        = d;
    shift_en   = se;
    acc        = 1'b0;
    if (rst_n && lv) begin
      if (load_ready_a[0]) begin
        wq0.push_back(d);
        acc = 1'b1;
      end
      if (load_ready_a[1]) wq1.push_back(d);
    end
  endtask

  task automatic idle(input int n, input logic se);
    bit a;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, se, a);
  endtask

  task automatic send(input logic [W-1:0] d);
    bit a;
    int tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 40) begin
      cyc(1'b1, d, 1'b1, a);
      tries++;
    end
    chk(a, "send_accept", 0, int'(a), 1);
  endtask

  // Monitor: checks every cycle, pops a bit whenever one is consumed.
  int bit_idx  [2];
  bit exp_done [2];
  bit prev_acc [2];

  initial begin
    logic [W-1:0] w;
    bit have;
    for (int k = 0; k < 2; k++) begin
      bit_idx[k] = 0; exp_done[k] = 1'b0; prev_acc[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          bit_idx[k] = 0; exp_done[k] = 1'b0; prev_acc[k] = 1'b0;
        end else begin
          if (prev_acc[k])
            chk(sout_valid_a[k] === 1'b1, "first_bit_latency", k, int'(sout_valid_a[k]), 1);
          chk(done_a[k] === exp_done[k], "done_pulse", k, int'(done_a[k]), int'(exp_done[k]));
          exp_done[k] = 1'b0;
          chk(sout_n_a[k] === ~sout_a[k], "sout_n_inverse", k, int'(sout_n_a[k]), int'(~sout_a[k]));
          chk(busy_a[k] === sout_valid_a[k], "busy_vs_valid", k, int'(busy_a[k]), int'(sout_valid_a[k]));
          chk(load_ready_a[k] === ~busy_a[k], "load_ready", k, int'(load_ready_a[k]), int'(~busy_a[k]));
          if (sout_valid_a[k] === 1'b1) begin
            have = (k == 0) ? (wq0.size() > 0) : (wq1.size() > 0);
            if (!have) begin
              chk(1'b0, "unexpected_bit", k, 1, 0);
            end else begin
              w = (k == 0) ? wq0[0] : wq1[0];
              chk(sout_a[k] === ref_bit(w, bit_idx[k], k), "sout_bit", k,
                  int'(sout_a[k]), int'(ref_bit(w, bit_idx[k], k)));
              if (shift_en) begin
                bit_idx[k]++;
                if (bit_idx[k] == W) begin
                  bit_idx[k] = 0;
                  exp_done[k] = 1'b1;
                  if (k == 0) void'(wq0.pop_front());
                  else        void'(wq1.pop_front());
                end
              end
            end
          end
          prev_acc[k] = load_valid && load_ready_a[k];
        end
      end
    end
  end

  // Stimulus: directed scenarios, an asynchronous abort, then random traffic.
  initial begin
    bit a;
    load_valid = 1'b0;
    din        = '0;
    shift_en   = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk(sout_a[k] === 1'b0, "rst_sout", k, int'(sout_a[k]), 0);
      chk(sout_n_a[k] === 1'b1, "rst_sout_n", k, int'(sout_n_a[k]), 1);
      chk(sout_valid_a[k] === 1'b0, "rst_valid", k, int'(sout_valid_a[k]), 0);
      chk(busy_a[k] === 1'b0, "rst_busy", k, int'(busy_a[k]), 0);
      chk(done_a[k] === 1'b0, "rst_done", k, int'(done_a[k]), 0);
      chk(load_ready_a[k] === 1'b1, "rst_load_ready", k, int'(load_ready_a[k]), 1);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;

    send(8'h1E);
    idle(10, 1'b1);

    send(8'hA5);
    idle(2, 1'b1);
    idle(3, 1'b0);
    idle(10, 1'b1);

    send(8'hFF);
    send(8'h00);
    idle(10, 1'b1);

    send(8'hF0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, 1'b1, a);
    idle(10, 1'b1);

    send(8'hC3);
    idle(4, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(sout_a[k] === 1'b0, "abort_sout", k, int'(sout_a[k]), 0);
      chk(sout_n_a[k] === 1'b1, "abort_sout_n", k, int'(sout_n_a[k]), 1);
      chk(sout_valid_a[k] === 1'b0, "abort_valid", k, int'(sout_valid_a[k]), 0);
      chk(busy_a[k] === 1'b0, "abort_busy", k, int'(busy_a[k]), 0);
      chk(done_a[k] === 1'b0, "abort_done", k, int'(done_a[k]), 0);
    end
    wq0.delete();
    wq1.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;

    send(8'h3C);
    idle(10, 1'b1);

    for (int i = 0; i < 600; i++)
      cyc(($urandom % 4) == 0, W'($urandom), ($urandom % 4) != 0, a);

    idle(20, 1'b1);
    chk(wq0.size() == 0, "drain_queue", 0, wq0.size(), 0);
    chk(wq1.size() == 0, "drain_queue", 1, wq1.size(), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
